// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared definitions for the Gray-code counter slice.
//                GRAY_DEFAULT_WIDTH is the default counter width.
//                GRAY_FUNC_WIDTH is the fixed width of the bin2gray helper.
//                bin2gray() is the binary-to-Gray helper. Narrower values are
//                zero-extended by the caller, and the result stays valid in
//                the low bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;
    localparam int GRAY_FUNC_WIDTH    = 32;

    // A zero-extended input leaves the upper result bits at zero, so a
    // caller can truncate the result back to its own width.
    function automatic logic [GRAY_FUNC_WIDTH-1:0] bin2gray(
        input logic [GRAY_FUNC_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_if
//  Description : Control and result bundle of the Gray-code counter.
//                master modport : the controller that drives en, dir, load and
//                                 load_val, and observes gray, count and wrap.
//                slave modport  : the counter itself.
//                Signals:
//                  en       - count enable
//                  dir      - 1 = up, 0 = down. Honoured only when the counter
//                             is built with GRAY_CNT_DOWN_EN.
//                  load     - synchronous parallel load
//                  load_val - binary value to load
//                  gray     - registered Gray code of the count
//                  count    - registered binary count
//                  wrap     - one-cycle wrap-around pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface gray_counter_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
);

    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] count;
    logic             wrap;

    modport master (
        output en,
        output dir,
        output load,
        output load_val,
        input  gray,
        input  count,
        input  wrap
    );

    modport slave (
        input  en,
        input  dir,
        input  load,
        input  load_val,
        output gray,
        output count,
        output wrap
    );

endinterface : gray_counter_if
`default_nettype wire

// File: rtl/gray_enc.sv
`default_nettype none
// ============================================================================
//  Module      : gray_enc
//  Description : Purely combinational binary-to-Gray encoder. It sits in front
//                of the gray output register.
//                Each Gray bit is the XOR of its binary bit and the next
//                higher binary bit. The MSB passes straight through.
//  Ports       : bin  [WIDTH-1:0] in  - binary value
//                gray [WIDTH-1:0] out - Gray-coded value
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  wire logic [WIDTH-1:0] bin,
    output logic      [WIDTH-1:0] gray
);

    assign gray[WIDTH-1] = bin[WIDTH-1];

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
        assign gray[i] = bin[i] ^ bin[i+1];
    end

endmodule : gray_enc
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Synchronous Gray-code counter. This is the source stage of
//                the Gray-to-binary converter chain.
//                A binary count is held internally. The Gray output is always
//                encoded from the next binary count and is never decoded from
//                the previous Gray value. A downstream converter therefore
//                reproduces count exactly on every cycle.
//                Each clock edge applies the first of these that is active:
//                  rst  : clear count, gray and wrap
//                  load : take load_val; wrap stays low
//                  en   : count by one in the selected direction
//                  hold : keep the count; wrap stays low
//                wrap pulses for one cycle when the count steps past its end
//                point: all-ones going up, or zero going down.
//  Config      : GRAY_CNT_DOWN_EN - when defined, dir selects up (1) or down
//                (0). When undefined, dir is ignored and no borrow or
//                down-count logic is built.
//  Ports       : clk - rising-edge clock
//                rst - synchronous active-high reset
//                bus - gray_counter_if.slave
//                      (en, dir, load, load_val -> gray, count, wrap)
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst,
    gray_counter_if.slave bus
);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;
    logic             w_at_max;
    logic             w_count_up;

    assign w_at_max = &r_count;

`ifdef GRAY_CNT_DOWN_EN
    logic w_at_zero;

    assign w_at_zero  = ~|r_count;
    assign w_count_up = bus.dir;
`else
    assign w_count_up = 1'b1;
`endif

    // rst is handled in the register process. Here, load has priority over
    // en, and a load always suppresses wrap, even when en is also high.
    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (bus.load) begin
            w_next_count = bus.load_val;
        end else if (bus.en) begin
            if (w_count_up) begin
                // The carry out is discarded. It is seen only as wrap.
                w_next_count = r_count + WIDTH'(1);
                w_next_wrap  = w_at_max;
            end
`ifdef GRAY_CNT_DOWN_EN
            else begin
                // The borrow out is discarded. It is seen only as wrap.
                w_next_count = r_count - WIDTH'(1);
                w_next_wrap  = w_at_zero;
            end
`endif
        end
    end

    // The Gray value is encoded from the next binary count, so gray and count
    // are updated by the same clock edge.
    gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .bin  (w_next_count),
        .gray (w_next_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_gray  <= w_next_gray;
            r_wrap  <= w_next_wrap;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from the registers, so no input reaches an
    // output combinationally.
    // ------------------------------------------------------------------------
    assign bus.count = r_count;
    assign bus.gray  = r_gray;
    assign bus.wrap  = r_wrap;

endmodule : gray_counter
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Self-checking bench for gray_counter (WIDTH = 4).
//                The bench applies directed vectors with hand-computed
//                expected values, then runs a chained check. In the chained
//                check, a Gray-to-binary converter model decodes gray, and the
//                decoded value must equal count on every cycle.
//  Config      : GRAY_CNT_DOWN_EN - when defined, the down-count vectors run,
//                and the random phase applies dir.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;
    import gray_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_counter_if #(.WIDTH(W)) bus ();

    gray_counter #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected up-count Gray sequence, starting from count 0.
    logic [W-1:0] up_gray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                   4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                   4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                   4'b1011, 4'b1001, 4'b1000, 4'b0000};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply the current inputs at one rising edge, then move to a point
    // clear of that edge for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream Gray-to-binary converter model.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    logic [W-1:0] prev_gray;
    logic [W-1:0] m_count;
    logic         m_wrap;
    logic         m_up;

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.dir      = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // Reset held for two cycles, with en high.
        step();
        step();
        check_eq("rst_count", 32'(bus.count), 32'h0);
        check_eq("rst_gray",  32'(bus.gray),  32'h0);
        check_eq("rst_wrap",  32'(bus.wrap),  32'h0);

        // Full up-count cycle through the wrap.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prev_gray = bus.gray;
            step();
            check_eq($sformatf("up_gray%0d", i), 32'(bus.gray), 32'(up_gray[i]));
            check_eq($sformatf("up_cnt%0d", i), 32'(bus.count), 32'((i + 1) % 16));
            check_eq($sformatf("up_wrap%0d", i), 32'(bus.wrap), (i == 15) ? 32'h1 : 32'h0);
            check_eq($sformatf("up_1bit%0d", i), 32'($countones(bus.gray ^ prev_gray)), 32'h1);
        end

`ifdef GRAY_CNT_DOWN_EN
        // Down from 0: borrow wraps to 1111.
        bus.dir = 1'b0;
        step();
        check_eq("dn_count", 32'(bus.count), 32'hF);
        check_eq("dn_gray",  32'(bus.gray),  32'h8);
        check_eq("dn_wrap",  32'(bus.wrap),  32'h1);
        step();
        check_eq("dn2_count", 32'(bus.count), 32'hE);
        check_eq("dn2_gray",  32'(bus.gray),  32'h9);
        check_eq("dn2_wrap",  32'(bus.wrap),  32'h0);
        bus.dir = 1'b1;
`endif

        // Load wins over en.
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        bus.en       = 1'b1;
        step();
        check_eq("ld_count", 32'(bus.count), 32'h9);
        check_eq("ld_gray",  32'(bus.gray),  32'hD);
        check_eq("ld_wrap",  32'(bus.wrap),  32'h0);
        bus.load = 1'b0;
        bus.en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("hold_count%0d", i), 32'(bus.count), 32'h9);
            check_eq($sformatf("hold_gray%0d", i),  32'(bus.gray),  32'hD);
            check_eq($sformatf("hold_wrap%0d", i),  32'(bus.wrap),  32'h0);
        end

        // Loading all-ones with en high gives no wrap. The next count wraps.
        bus.load     = 1'b1;
        bus.load_val = 4'hF;
        bus.en       = 1'b1;
        step();
        check_eq("ldmax_wrap", 32'(bus.wrap), 32'h0);
        check_eq("ldmax_gray", 32'(bus.gray), 32'h8);
        bus.load = 1'b0;
        step();
        check_eq("ldwrap_count", 32'(bus.count), 32'h0);
        check_eq("ldwrap_wrap",  32'(bus.wrap),  32'h1);

        // Mid-count reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("mid_count", 32'(bus.count), 32'h6);
        check_eq("mid_gray",  32'(bus.gray),  32'h5);
        rst = 1'b1;
        step();
        check_eq("mrst_gray",  32'(bus.gray),  32'h0);
        check_eq("mrst_count", 32'(bus.count), 32'h0);
        check_eq("mrst_wrap",  32'(bus.wrap),  32'h0);
        rst = 1'b0;
        step();
        check_eq("resume_gray",  32'(bus.gray),  32'h1);
        check_eq("resume_count", 32'(bus.count), 32'h1);

        // Chained check with random en, dir and load.
        m_count = 4'd1;
        for (int i = 0; i < 40; i++) begin
            bus.en       = 1'($urandom_range(0, 1));
            bus.dir      = 1'($urandom_range(0, 1));
            bus.load     = ($urandom_range(0, 3) == 0);
            bus.load_val = 4'($urandom_range(0, 15));
`ifdef GRAY_CNT_DOWN_EN
            m_up = bus.dir;
`else
            m_up = 1'b1;
`endif
            m_wrap = 1'b0;
            if (bus.load) begin
                m_count = bus.load_val;
            end else if (bus.en) begin
                if (m_up) begin
                    m_wrap  = (m_count == 4'hF);
                    m_count = m_count + 4'd1;
                end else begin
                    m_wrap  = (m_count == 4'h0);
                    m_count = m_count - 4'd1;
                end
            end
            step();
            check_eq($sformatf("chain%0d", i), 32'(gray2bin(bus.gray)), 32'(bus.count));
            check_eq($sformatf("rnd_count%0d", i), 32'(bus.count), 32'(m_count));
            check_eq($sformatf("rnd_gray%0d", i), 32'(bus.gray), bin2gray(32'(m_count)));
            check_eq($sformatf("rnd_wrap%0d", i), 32'(bus.wrap), 32'(m_wrap));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_gray_counter
`default_nettype wire
